// File: rtl/traffic_pkg.sv
// Shared types and encodings for the traffic light controller.
//   phase_t      : signal phases, plus the terminal FAULT phase
//   sub_t        : per-phase substate (ISSUE = timer start cycle, WAIT = timer running)
//   LIGHT_*      : one-hot {red,yellow,green} lamp encodings
//   next_phase() : phase rotation, with the walk phase inserted after ALL_RED_2
//   phase_lights(): {ns, ew} lamp pattern for a phase
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED_2 = 3'd0,
    PH_WALK      = 3'd1,
    PH_NS_GREEN  = 3'd2,
    PH_NS_YELLOW = 3'd3,
    PH_ALL_RED_1 = 3'd4,
    PH_EW_GREEN  = 3'd5,
    PH_EW_YELLOW = 3'd6,
    PH_FAULT     = 3'd7
  } phase_t;

  typedef enum logic {
    SUB_ISSUE = 1'b0,
    SUB_WAIT  = 1'b1
  } sub_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  function automatic phase_t next_phase(input phase_t ph, input logic ped_pending);
    phase_t nxt;
    case (ph)
      PH_ALL_RED_2: nxt = ped_pending ? PH_WALK : PH_NS_GREEN;
      PH_WALK:      nxt = PH_NS_GREEN;
      PH_NS_GREEN:  nxt = PH_NS_YELLOW;
      PH_NS_YELLOW: nxt = PH_ALL_RED_1;
      PH_ALL_RED_1: nxt = PH_EW_GREEN;
      PH_EW_GREEN:  nxt = PH_EW_YELLOW;
      PH_EW_YELLOW: nxt = PH_ALL_RED_2;
      default:      nxt = PH_FAULT;
    endcase
    return nxt;
  endfunction

  // Returns {ns, ew}.
  function automatic logic [5:0] phase_lights(input phase_t ph);
    logic [5:0] l;
    case (ph)
      PH_NS_GREEN:  l = {LIGHT_GREEN,  LIGHT_RED};
      PH_NS_YELLOW: l = {LIGHT_YELLOW, LIGHT_RED};
      PH_EW_GREEN:  l = {LIGHT_RED,    LIGHT_GREEN};
      PH_EW_YELLOW: l = {LIGHT_RED,    LIGHT_YELLOW};
      default:      l = {LIGHT_RED,    LIGHT_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Watchdog for the WAIT substate: a down-counter reloaded with `limit` on
// clear, decremented on each enabled cycle, flagging the last allowed cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (reloads the counter)
//   clear     : reload to limit (driven during ISSUE)
//   enable    : count this cycle (driven during WAIT)
//   limit     : number of enabled cycles allowed
//   expired   : this enabled cycle is the limit-th one
module wait_watchdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] remaining;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      remaining <= limit;
    end else if (enable && (remaining != 8'd0)) begin
      remaining <= remaining - 8'd1;
    end
  end

  // Terminal count at 1 so the fault is taken on the edge closing the
  // limit-th WAIT cycle, not one cycle later.
  assign expired = enable && (remaining <= 8'd1);

endmodule

// File: rtl/traffic_light_controller.sv
// Intersection sequencer: rotates NS/EW green-yellow-red phases with all-red
// clearances, an optional pedestrian walk phase, and a watchdog on the
// external phase timer that drops into a sticky flashing-red fault.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   timer_done          : phase timer elapsed (one-cycle pulse)
//   ped_req             : pedestrian request, latched until WALK is entered
//   timer_go, timer_len : phase timer start pulse and duration code
//   ns_light, ew_light  : one-hot {red,yellow,green} lamps
//   walk                : pedestrian walk lamp
//   fault               : sticky watchdog fault
//
// phase        | meaning
// ALL_RED_2    | clearance before NS (and walk decision point)
// WALK         | pedestrian crossing, all traffic red
// NS_GREEN     | north-south go
// NS_YELLOW    | north-south caution
// ALL_RED_1    | clearance before EW
// EW_GREEN     | east-west go
// EW_YELLOW    | east-west caution
// FAULT        | timer lost; flash red, wait for reset
// Each non-fault phase has substates ISSUE (one cycle, starts timer) and WAIT.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter logic [3:0] GREEN_LEN  = 4'hA,
  parameter logic [3:0] YELLOW_LEN = 4'h3,
  parameter logic [3:0] RED_LEN    = 4'h1,
  parameter logic [3:0] WALK_LEN   = 4'h8,
  parameter logic [7:0] TIMEOUT    = 8'd64,
  parameter logic [3:0] FLASH_HALF = 4'h8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_done,
  input  logic       ped_req,
  output logic       timer_go,
  output logic [3:0] timer_len,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       fault
);

  phase_t     phase;
  sub_t       sub;
  logic       started;
  logic       ped_latch;
  logic [3:0] flash_cnt;
  logic       wd_expired;

  phase_t     enter_ph;
  logic       advance;
  logic       enter_walk;

  function automatic logic [3:0] phase_len(input phase_t ph);
    logic [3:0] len;
    case (ph)
      PH_ALL_RED_1, PH_ALL_RED_2: len = RED_LEN;
      PH_WALK:                    len = WALK_LEN;
      PH_NS_GREEN, PH_EW_GREEN:   len = GREEN_LEN;
      PH_NS_YELLOW, PH_EW_YELLOW: len = YELLOW_LEN;
      default:                    len = 4'h0;
    endcase
    return len;
  endfunction

  // Reset parks the FSM in ALL_RED_2/ISSUE with outputs quiet; the first
  // edge out of reset presents that ISSUE (timer_go) rather than skipping it.
  always_comb begin
    enter_ph   = started ? next_phase(phase, ped_latch) : PH_ALL_RED_2;
    advance    = (phase != PH_FAULT) &&
                 (!started || ((sub == SUB_WAIT) && timer_done));
    enter_walk = advance && (enter_ph == PH_WALK);
  end

  wait_watchdog u_wait_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (sub == SUB_ISSUE),
    .enable  ((sub == SUB_WAIT) && (phase != PH_FAULT)),
    .limit   (TIMEOUT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PH_ALL_RED_2;
      sub       <= SUB_ISSUE;
      started   <= 1'b0;
      ped_latch <= 1'b0;
      flash_cnt <= 4'd0;
      timer_go  <= 1'b0;
      timer_len <= 4'h0;
      ns_light  <= LIGHT_RED;
      ew_light  <= LIGHT_RED;
      walk      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      // Entering WALK consumes the request, even one arriving on that edge.
      if (enter_walk) begin
        ped_latch <= 1'b0;
      end else if (ped_req) begin
        ped_latch <= 1'b1;
      end

      if (phase == PH_FAULT) begin
        if (flash_cnt == 4'd0) begin
          ns_light  <= (ns_light == LIGHT_RED) ? LIGHT_DARK : LIGHT_RED;
          ew_light  <= (ew_light == LIGHT_RED) ? LIGHT_DARK : LIGHT_RED;
          flash_cnt <= FLASH_HALF - 4'd1;
        end else begin
          flash_cnt <= flash_cnt - 4'd1;
        end
      end else if (advance) begin
        started                <= 1'b1;
        phase                  <= enter_ph;
        sub                    <= SUB_ISSUE;
        timer_go               <= 1'b1;
        timer_len              <= phase_len(enter_ph);
        {ns_light, ew_light}   <= phase_lights(enter_ph);
        walk                   <= (enter_ph == PH_WALK);
      end else if (sub == SUB_ISSUE) begin
        sub      <= SUB_WAIT;
        timer_go <= 1'b0;
      end else if (wd_expired) begin
        phase     <= PH_FAULT;
        fault     <= 1'b1;
        walk      <= 1'b0;
        timer_go  <= 1'b0;
        ns_light  <= LIGHT_RED;
        ew_light  <= LIGHT_RED;
        flash_cnt <= FLASH_HALF - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timer_done = 1'b0;
  logic       ped_req = 1'b0;
  logic       timer_go;
  logic [3:0] timer_len;
  logic [2:0] ns_light, ew_light;
  logic       walk, fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut (
    .clk        (clk),
    .rst        (rst),
    .timer_done (timer_done),
    .ped_req    (ped_req),
    .timer_go   (timer_go),
    .timer_len  (timer_len),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .fault      (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase indices follow the rotation order so most advances are index+1.
  localparam int M_AR2 = 0, M_WALK = 1, M_NSG = 2, M_NSY = 3, M_AR1 = 4, M_EWG = 5, M_EWY = 6;

  typedef struct {
    logic [3:0] len;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } vec_t;

  vec_t ph_tab[7];
  vec_t seq[7];

  bit m_quiet = 1'b1;
  bit m_issue = 1'b0;
  bit m_fault = 1'b0;
  bit m_ped   = 1'b0;
  int m_phase = M_AR2;
  int m_wait  = 0;
  int m_age   = 0;
  bit mr, md, mp, m_ent;
  int np;
  logic       e_go, e_walk, e_fault, len_chk;
  logic [3:0] e_len;
  logic [2:0] e_ns, e_ew;

  always @(posedge clk) begin
    mr = rst; md = timer_done; mp = ped_req; m_ent = 1'b0;
    if (mr) begin
      m_quiet = 1'b1; m_fault = 1'b0; m_ped = 1'b0; m_issue = 1'b0;
      m_phase = M_AR2; m_wait = 0;
    end else begin
      if (m_fault) begin
        m_age++;
      end else if (m_quiet) begin
        m_quiet = 1'b0; m_issue = 1'b1; m_phase = M_AR2;
      end else if (m_issue) begin
        m_issue = 1'b0; m_wait = 0;
      end else if (md) begin
        if (m_phase == M_AR2)      np = m_ped ? M_WALK : M_NSG;
        else if (m_phase == M_EWY) np = M_AR2;
        else                       np = m_phase + 1;
        m_ent = (np == M_WALK);
        m_phase = np; m_issue = 1'b1;
      end else begin
        m_wait++;
        if (m_wait == 64) begin m_fault = 1'b1; m_age = 0; end
      end
      if (m_ent) m_ped = 1'b0;
      else if (mp) m_ped = 1'b1;
    end
    #1;
    len_chk = 1'b1; e_len = 4'h0;
    if (m_quiet) begin
      e_go = 1'b0; e_ns = 3'b100; e_ew = 3'b100; e_walk = 1'b0; e_fault = 1'b0;
    end else if (m_fault) begin
      e_go = 1'b0; e_walk = 1'b0; e_fault = 1'b1; len_chk = 1'b0;
      e_ns = (((m_age / 8) % 2) == 0) ? 3'b100 : 3'b000;
      e_ew = e_ns;
    end else begin
      e_go = m_issue; e_fault = 1'b0;
      e_ns = ph_tab[m_phase].ns; e_ew = ph_tab[m_phase].ew; e_walk = ph_tab[m_phase].walk;
      len_chk = m_issue; e_len = ph_tab[m_phase].len;
    end
    check("model", {20'd0, timer_go, (len_chk ? timer_len : 4'h0), ns_light, ew_light, walk, fault},
                   {20'd0, e_go, (len_chk ? e_len : 4'h0), e_ns, e_ew, e_walk, e_fault});
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (timer_go !== 1'b1 && n < 8) begin tick(); n++; end
    check(name, {31'd0, timer_go}, 32'd1);
  endtask

  // From a timer_go cycle: pulse timer_done three cycles later, land on the next go.
  task automatic pulse_done();
    tick(); tick();
    timer_done = 1'b1; tick(); timer_done = 1'b0;
    wait_go("go_after_done");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ns"},    {29'd0, ns_light}, 32'h4);
    check({tag, "_ew"},    {29'd0, ew_light}, 32'h4);
    check({tag, "_walk"},  {31'd0, walk}, 32'd0);
    check({tag, "_go"},    {31'd0, timer_go}, 32'd0);
    check({tag, "_len"},   {28'd0, timer_len}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int hold;

  initial begin
    ph_tab[M_AR2]  = '{len: 4'h1, ns: 3'b100, ew: 3'b100, walk: 1'b0};
    ph_tab[M_WALK] = '{len: 4'h8, ns: 3'b100, ew: 3'b100, walk: 1'b1};
    ph_tab[M_NSG]  = '{len: 4'hA, ns: 3'b001, ew: 3'b100, walk: 1'b0};
    ph_tab[M_NSY]  = '{len: 4'h3, ns: 3'b010, ew: 3'b100, walk: 1'b0};
    ph_tab[M_AR1]  = '{len: 4'h1, ns: 3'b100, ew: 3'b100, walk: 1'b0};
    ph_tab[M_EWG]  = '{len: 4'hA, ns: 3'b100, ew: 3'b001, walk: 1'b0};
    ph_tab[M_EWY]  = '{len: 4'h3, ns: 3'b100, ew: 3'b010, walk: 1'b0};

    seq[0] = '{len: 4'h1, ns: 3'b100, ew: 3'b100, walk: 1'b0};
    seq[1] = '{len: 4'hA, ns: 3'b001, ew: 3'b100, walk: 1'b0};
    seq[2] = '{len: 4'h3, ns: 3'b010, ew: 3'b100, walk: 1'b0};
    seq[3] = '{len: 4'h1, ns: 3'b100, ew: 3'b100, walk: 1'b0};
    seq[4] = '{len: 4'hA, ns: 3'b100, ew: 3'b001, walk: 1'b0};
    seq[5] = '{len: 4'h3, ns: 3'b100, ew: 3'b010, walk: 1'b0};
    seq[6] = '{len: 4'h1, ns: 3'b100, ew: 3'b100, walk: 1'b0};

    // Reset and first issue
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check("first_go", {31'd0, timer_go}, 32'd1);
    check("first_len", {28'd0, timer_len}, 32'h1);

    // Full rotation from the vector table
    for (int i = 0; i < 7; i++) begin
      if (i > 0) pulse_done();
      check("seq_len",  {28'd0, timer_len}, {28'd0, seq[i].len});
      check("seq_ns",   {29'd0, ns_light},  {29'd0, seq[i].ns});
      check("seq_ew",   {29'd0, ew_light},  {29'd0, seq[i].ew});
      check("seq_walk", {31'd0, walk},      {31'd0, seq[i].walk});
    end

    // timer_done during ISSUE only: must be ignored
    timer_done = 1'b1; tick(); timer_done = 1'b0;
    check("issue_done_go", {31'd0, timer_go}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("issue_done_stay", {31'd0, timer_go}, 32'd0);
    end
    timer_done = 1'b1; tick(); timer_done = 1'b0;
    check("issue_done_adv_go", {31'd0, timer_go}, 32'd1);
    check("issue_done_adv_len", {28'd0, timer_len}, 32'hA);

    // ped request during EW_GREEN
    pulse_done(); pulse_done(); pulse_done();          // NSY, AR1, EWG
    check("ewg_len", {28'd0, timer_len}, 32'hA);
    ped_req = 1'b1; tick(); ped_req = 1'b0; tick();
    timer_done = 1'b1; tick(); timer_done = 1'b0;      // EWY
    check("ewy_len", {28'd0, timer_len}, 32'h3);
    pulse_done();                                       // AR2
    pulse_done();                                       // WALK
    check("walk_len",  {28'd0, timer_len}, 32'h8);
    check("walk_walk", {31'd0, walk}, 32'd1);
    check("walk_ns",   {29'd0, ns_light}, 32'h4);
    check("walk_ew",   {29'd0, ew_light}, 32'h4);
    tick();
    check("walk_wait_walk", {31'd0, walk}, 32'd1);
    timer_done = 1'b1; tick(); timer_done = 1'b0;      // NSG
    check("post_walk_len", {28'd0, timer_len}, 32'hA);
    check("post_walk_walk", {31'd0, walk}, 32'd0);
    repeat (5) pulse_done();                            // to AR2
    pulse_done();
    check("no_rewalk_len", {28'd0, timer_len}, 32'hA);
    check("no_rewalk_walk", {31'd0, walk}, 32'd0);

    // ped_req coinciding with WALK entry edge is consumed
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    timer_done = 1'b1; tick(); timer_done = 1'b0;      // NSY
    wait_go("go_nsy");
    repeat (4) pulse_done();                            // AR1, EWG, EWY, AR2
    tick(); tick();
    timer_done = 1'b1; ped_req = 1'b1; tick(); timer_done = 1'b0; ped_req = 1'b0;
    check("edge_walk", {31'd0, walk}, 32'd1);
    check("edge_walk_len", {28'd0, timer_len}, 32'h8);
    pulse_done();                                       // NSG
    repeat (5) pulse_done();                            // AR2
    pulse_done();
    check("consumed_len", {28'd0, timer_len}, 32'hA);
    check("consumed_walk", {31'd0, walk}, 32'd0);

    // reset during NS_YELLOW WAIT
    pulse_done();                                       // NSY
    tick(); tick();
    rst = 1'b1; tick();
    check_reset_outputs("rst_nsy");
    tick();
    rst = 1'b0; tick();
    check("rst_nsy_go", {31'd0, timer_go}, 32'd1);
    check("rst_nsy_len", {28'd0, timer_len}, 32'h1);

    // watchdog fault: timer_done withheld in AR2 WAIT
    repeat (64) tick();
    check("pre_fault", {31'd0, fault}, 32'd0);
    tick();
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_ns0", {29'd0, ns_light}, 32'h4);
    check("fault_go",  {31'd0, timer_go}, 32'd0);
    repeat (7) tick();
    check("flash_age7", {29'd0, ns_light}, 32'h4);
    tick();
    check("flash_age8_ns", {29'd0, ns_light}, 32'h0);
    check("flash_age8_ew", {29'd0, ew_light}, 32'h0);
    repeat (7) tick();
    check("flash_age15", {29'd0, ew_light}, 32'h0);
    tick();
    check("flash_age16", {29'd0, ns_light}, 32'h4);
    timer_done = 1'b1; tick(); timer_done = 1'b0;
    check("fault_done_fault", {31'd0, fault}, 32'd1);
    check("fault_done_go", {31'd0, timer_go}, 32'd0);
    tick();
    check("fault_done_go2", {31'd0, timer_go}, 32'd0);
    rst = 1'b1; tick();
    check_reset_outputs("rst_fault");
    rst = 1'b0; tick();
    check("rst_fault_go", {31'd0, timer_go}, 32'd1);
    check("rst_fault_len", {28'd0, timer_len}, 32'h1);

    // Randomized traffic checked by the model each cycle
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold > 0) begin
        timer_done = 1'b0;
        hold--;
      end else begin
        timer_done = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 149) == 0) hold = $urandom_range(40, 90);
      end
      ped_req = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; timer_done = 1'b0; ped_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 SHALL have parameter GREEN_LEN, default 4'hA, timer duration code for a green phase.
REQ-002 SHALL have parameter YELLOW_LEN, default 4'h3, timer duration code for a yellow phase.
REQ-003 SHALL have parameter RED_LEN, default 4'h1, timer duration code for an all-red clearance phase.
REQ-004 SHALL have parameter WALK_LEN, default 4'h8, timer duration code for the pedestrian walk phase.
REQ-005 SHALL have parameter TIMEOUT, default 8'd64, maximum cycles to wait for timer_done before faulting.
REQ-006 SHALL have parameter FLASH_HALF, default 4'h8, half-period in cycles of the fault flash.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have port timer_done, input, 1, one-cycle pulse from the phase timer: duration elapsed.
REQ-010 SHALL have port ped_req, input, 1, pedestrian request; any cycle high registers a request.
REQ-011 SHALL have port timer_go, output, 1, one-cycle pulse starting the phase timer.
REQ-012 SHALL have port timer_len, output, 4, duration code of the current phase; valid whenever timer_go=1.
REQ-013 SHALL have ports ns_light and ew_light, output, 3 each, one-hot {red,yellow,green}: 100 red, 010 yellow, 001 green, 000 dark.
REQ-014 SHALL have port walk, output, 1, pedestrian walk indication.
REQ-015 SHALL have port fault, output, 1, sticky watchdog fault flag.

Function
REQ-016 SHALL sequence phases ALL_RED_2 -> [WALK if request latched] -> NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2, repeating.
REQ-017 SHALL split each phase into substates ISSUE (exactly one cycle) and WAIT.
REQ-018 SHALL assert timer_go=1 and timer_len=<phase LEN> only in ISSUE; timer_go=0 at all other times.
REQ-019 SHALL advance to the next phase's ISSUE on the edge after timer_done=1 is sampled in WAIT.
REQ-020 SHALL ignore timer_done sampled in ISSUE, in FAULT, or during reset.
REQ-021 SHALL drive lights as: NS_GREEN ns=001/ew=100; NS_YELLOW ns=010/ew=100; EW_GREEN ns=100/ew=001; EW_YELLOW ns=100/ew=010; ALL_RED_x and WALK both 100.
REQ-022 SHALL drive walk=1 only in WALK (both substates); no green or yellow ever coincides with walk=1.
REQ-023 SHALL set a sticky ped latch on any cycle with ped_req=1 and clear it on entry to WALK.
REQ-024 SHALL consume a ped_req coinciding with the WALK entry edge; a ped_req during WALK after entry re-arms the latch.
REQ-025 SHALL count WAIT cycles in an 8-bit watchdog, cleared on every ISSUE.
REQ-026 SHALL enter FAULT when the watchdog reaches TIMEOUT without timer_done.
REQ-027 SHALL, in FAULT, set fault=1, walk=0, timer_go=0, and toggle ns/ew together between 100 and 000 every FLASH_HALF cycles, starting at 100.
REQ-028 SHALL leave FAULT only by rst.
REQ-029 SHALL change all outputs registered, on the same edge as the state change.

Reset
REQ-030 SHALL, while rst=1 at an edge, load phase ALL_RED_2 substate ISSUE, clear the ped latch, watchdog and flash counter, and set fault=0.
REQ-031 SHALL hold outputs ns=100, ew=100, walk=0, timer_go=0, timer_len=0, fault=0 during reset.
REQ-032 SHALL assert timer_go=1 with timer_len=RED_LEN in the first cycle after rst deasserts.
REQ-033 SHALL give rst asserted mid-phase or in FAULT priority over all other events, aborting the phase immediately.

Structure
REQ-034 SHALL place the phase enum, substate enum and light encodings (RED/YELLOW/GREEN/DARK) in shared package traffic_pkg.
REQ-035 SHALL implement the timeout counter as a sub-module wait_watchdog (clk, rst, clear, enable, limit -> expired).

Verification
REQ-036 SHALL test: rst released, timer_done pulsed 3 cycles after each timer_go -> timer_len sequence 1,A,3,1,A,3,1 with lights per REQ-021.
REQ-037 SHALL test: ped_req pulsed during EW_GREEN -> after ALL_RED_2, WALK with timer_len=8, walk=1, both lights 100; the next cycle skips WALK.
REQ-038 SHALL test: timer_done held high in the ISSUE cycle only -> no advance, and the FSM stays in WAIT.
REQ-039 SHALL test: timer_done withheld for 64 WAIT cycles -> fault=1, lights flash 100/000 every 8 cycles, timer_go stays 0, and later timer_done has no effect.
REQ-040 SHALL test: rst pulsed during NS_YELLOW WAIT and again in FAULT -> reset outputs per REQ-031, then timer_go with timer_len=1 in the first cycle after release.
REQ-041 SHALL test: ped_req asserted exactly on the WALK entry edge -> consumed; no second WALK in the following cycle.
